// File: rtl/klingon_pkg.sv
// Shared types and helpers for the Klingon BCD counter front end.
package klingon_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  // Saturate an arbitrary 4-bit load value into the legal BCD range.
  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/klingon_bcd_counter_digit.sv
// One mod-10 up/down BCD digit with synchronous load and a same-cycle wrap flag.
module bcd_digit
  import klingon_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             wrap
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  // wrap feeds the next digit's enable on the same edge, so it is combinational.
  assign wrap = en & (up ? (q_q >= BCD_MAX) : (q_q == '0));
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      if (up) begin
        q_d = (q_q >= BCD_MAX) ? '0 : BCD_W'(q_q + 1'b1);
      end else begin
        q_d = (q_q == '0) ? BCD_MAX : BCD_W'(q_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/klingon_bcd_counter.sv
// Two-digit BCD up/down counter with prescaler, run/stop control and parallel load.
module klingon_bcd_counter
  import klingon_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  output logic [BCD_W-1:0] tens_q,
  output logic [BCD_W-1:0] ones_q,
  output logic             running,
  output logic             step,
  output logic             carry
);

  localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  state_e            state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              step_q, step_d;
  logic              carry_q, carry_d;
  logic              step_fire_c;
  logic              ones_wrap;
  logic              tens_wrap;

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    step_fire_c = 1'b0;
    step_d      = 1'b0;
    carry_d     = 1'b0;

    // stop dominates start in both states
    unique case (state_q)
      STOPPED: if (start && !stop) state_d = RUNNING;
      RUNNING: if (stop)           state_d = STOPPED;
      default: state_d = STOPPED;
    endcase

    // A stop edge neither steps nor advances the prescaler, so pause preserves phase.
    step_fire_c = (state_q == RUNNING) && !stop && !load && (pcnt_q == PCNT_LAST);

    if (load) begin
      pcnt_d = '0;
    end else if ((state_q == RUNNING) && !stop) begin
      pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : PCNT_W'(pcnt_q + 1'b1);
    end

    step_d  = step_fire_c;
    carry_d = step_fire_c & tens_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      pcnt_q  <= '0;
      step_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      step_q  <= step_d;
      carry_q <= carry_d;
    end
  end

  bcd_digit u_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step_fire_c),
    .up    (up),
    .load  (load),
    .d     (clamp_bcd(load_ones)),
    .q     (ones_q),
    .wrap  (ones_wrap)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step_fire_c & ones_wrap),
    .up    (up),
    .load  (load),
    .d     (clamp_bcd(load_tens)),
    .q     (tens_q),
    .wrap  (tens_wrap)
  );

  assign running = (state_q == RUNNING);
  assign step    = step_q;
  assign carry   = carry_q;

endmodule

// File: doc/klingon_bcd_counter.md
# klingon_bcd_counter

Two-digit BCD up/down counter that produces the 4-bit digit codes consumed by the Klingon 7-segment decoder stage. It is the stage directly upstream of that decoder. One decoder instance is fed from `ones_q` and one from `tens_q`. A prescaler, a run/stop control FSM and a synchronous parallel load make it usable as a lab stopwatch or counter front end.

## Interface
- `PRESCALE`, default 4: number of RUNNING clock cycles per count step; legal range ≥ 1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  level sampled each cycle; requests STOPPED→RUNNING.
- `stop`  in  1  level sampled each cycle; requests RUNNING→STOPPED.
- `up`  in  1  count direction: 1 = increment, 0 = decrement; sampled on step cycles only.
- `load`  in  1  synchronous parallel load of both digits.
- `load_tens`  in  4  tens value for load.
- `load_ones`  in  4  ones value for load.
- `tens_q`  out  4  tens digit, BCD 0–9. Bit 3 is the MSB and drives decoder input I0; bit 0 drives I3.
- `ones_q`  out  4  ones digit, same bit mapping as `tens_q`.
- `running`  out  1  high in RUNNING state.
- `step`  out  1  one-cycle pulse; counter advanced on the preceding edge.
- `carry`  out  1  one-cycle pulse; that advance wrapped 99→00 (up) or 00→99 (down).

## Operation
- FSM states:
  - STOPPED: reset state.
  - RUNNING.
- FSM transitions:
  - STOPPED→RUNNING when `start`=1 and `stop`=0.
  - RUNNING→STOPPED when `stop`=1.
  - `start` and `stop` asserted together: `stop` wins in either state.
- Prescaler `pcnt`, range 0..PRESCALE-1:
  - Increments only while RUNNING.
  - Holds its value in STOPPED, so stop is a pause, not a restart.
  - Cleared by reset and by `load`.
- A step occurs when RUNNING and `pcnt`=PRESCALE-1 and `load`=0. On that edge `pcnt` returns to 0.
- Step, up:
  - `ones_q` increments.
  - At 9, ones wraps to 0 and tens increments.
  - Tens at 9 wraps to 0 and `carry` is generated.
- Step, down: mirror image. Ones at 0 wraps to 9 and borrows from tens; tens at 0 wraps to 9 and `carry` is generated.
- Load:
  - Has priority over step; a step coinciding with load is discarded.
  - Load values greater than 9 are clamped to 9 per digit.
  - Load does not change FSM state.
  - Load in RUNNING resumes counting from the loaded value, with a full PRESCALE-cycle interval to the first step.
- Digit outputs never leave 0–9 under any input sequence.
- Reset values: `tens_q`=0, `ones_q`=0, `running`=0, `step`=0, `carry`=0, `pcnt`=0, FSM=STOPPED.
- `rst_n`=0 has priority over every other input. Reset asserted mid-count discards the count and any pending step/carry pulse on the same edge.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `start` sampled at edge k: `running`=1 after edge k. With PRESCALE=P, the first step edge is k+P and `step` is high in the cycle after that edge.
- `step` and `carry` are high for exactly one cycle, in the same cycle as the new digit values. `carry` is never high without `step`.
- PRESCALE=1: a step on every RUNNING edge; `step` stays continuously high while RUNNING with no load.
- `stop` sampled at edge k: no step occurs on edge k even if `pcnt`=PRESCALE-1.
- `load` sampled at edge k: loaded digits are visible after edge k, and `step`=0 in the following cycle.
- Direction change takes effect on the next step edge; there is no extra latency.

## Structure
- Shared package `klingon_pkg` holds:
  - `BCD_W`=4 and `BCD_MAX`=4'd9.
  - The FSM state encoding (STOPPED=1'b0, RUNNING=1'b1).
  - The clamp function for load values.
- Sub-module `bcd_digit`, instantiated twice (ones, tens). It is one mod-10 up/down digit with inputs `en`, `up`, `load`, `d`; outputs `q` and `wrap`. Ones `wrap` gates the tens `en`.
- The top level holds the FSM, the prescaler, and the `step`/`carry` output registers.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `start`=1 → all outputs 0 and `running`=0. Release with `start`=1 → `running`=1 after the next edge.
- Up count, PRESCALE=4: load 9/8 then start, `up`=1.
  - `step` asserts every 4 cycles.
  - Sequence 98, 99, 00; `carry`=1 only with 00.
- Down count: load 0/1, `up`=0 → 00, then 99 with `carry`=1, then 98.
- Pause/resume: stop with `pcnt`=2, hold 10 cycles, then start.
  - Digits are frozen while stopped.
  - The next step comes 2 RUNNING cycles after resume (`pcnt` preserved).
- Priority: `load` (tens=12, ones=15) on the same edge as a step → outputs 9/9, `step`=0, `carry`=0. Then `start`+`stop` together in STOPPED → stays STOPPED.
- Reset mid-run at 45 with a step due → next cycle 00, `step`=0, `running`=0.
